// File: rtl/attn_ram_reader_pkg.sv
// Shared types and constants for the attention-buffer read controller.
package attn_ram_reader_pkg;

  typedef enum logic [2:0] {
    WAIT,
    READ,
    DRAIN,
    REL,
    GAP
  } attnRdState_t;

  localparam int ATTN_GAP_CYCLES = 2;
  localparam int ATTN_SKID_DEPTH = 2;

endpackage

// File: rtl/attn_ram_reader_skid.sv
// attn_rd_skid: two-entry FIFO that catches BRAM returns (data plus coordinates)
// so the read pipeline never has to stall on the downstream ready.
module attn_rd_skid #(
  parameter int EW = 8
) (
  input  logic          s_clk,
  input  logic          s_rst_n,
  input  logic          push,
  input  logic [EW-1:0] pushEntry,
  input  logic          pop,
  output logic [EW-1:0] headEntry,
  output logic [1:0]    count
);
  import attn_ram_reader_pkg::*;

  logic [EW-1:0] mem [ATTN_SKID_DEPTH];
  logic          wrPtr;
  logic          rdPtr;

  // Push and pop are independent; the issuer's credit check prevents overflow.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wrPtr  <= 1'b0;
      rdPtr  <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wrPtr] <= pushEntry;
        wrPtr      <= ~wrPtr;
      end
      if (pop) begin
        rdPtr <= ~rdPtr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign headEntry = mem[rdPtr];

endmodule

// File: rtl/attn_ram_reader.sv
// Read-side controller for the ping-pong attention buffer; streams each filled bank
// PASSES times and releases it. Define ATTN_RD_COLMAJOR_EN for the transposed sweep.
module attn_ram_reader
  import attn_ram_reader_pkg::*;
#(
  parameter  int DATA_W  = 20,
  parameter  int FMAP_W  = 64,
  parameter  int ADDR_W  = 12,
  parameter  int PASSES  = 1,
  localparam int COORD_W = $clog2(FMAP_W)
) (
  input  logic               s_clk,
  input  logic               s_rst_n,
  input  logic               i_AttnRAM_Empty,
  input  logic [DATA_W-1:0]  i_AttnRAM_data,
  output logic [ADDR_W-1:0]  o_AttnRam_rd_addr,
  output logic               o_AttnRam_Done,
  output logic [DATA_W-1:0]  m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [COORD_W-1:0] m_row,
  output logic [COORD_W-1:0] m_col,
  output logic [3:0]         m_pass,
  output logic               m_last
);

  localparam int                 EW        = DATA_W + 2*COORD_W + 5;
  localparam logic [COORD_W-1:0] lastCoord = COORD_W'(FMAP_W - 1);
  localparam logic [3:0]         lastPass  = 4'(PASSES - 1);

  attnRdState_t       state;
  logic [COORD_W-1:0] row;
  logic [COORD_W-1:0] col;
  logic [3:0]         pass;
  logic [1:0]         gapCnt;
  logic               inflight;
  logic [COORD_W-1:0] rowQ;
  logic [COORD_W-1:0] colQ;
  logic [3:0]         passQ;
  logic               lastQ;
  logic [1:0]         skidCount;
  logic [EW-1:0]      headEntry;
  logic [2:0]         outstanding;
  logic               issue;
  logic               pop;
  logic               lastIssue;
  logic               bankWrap;

  // The address port shows the word being read in an issue cycle and stays put otherwise.
  assign o_AttnRam_rd_addr = ADDR_W'(row) * ADDR_W'(FMAP_W) + ADDR_W'(col);

  assign m_valid     = (skidCount != 2'd0);
  assign pop         = m_valid & m_ready;
  assign outstanding = {1'b0, skidCount} - {2'b00, pop} + {2'b00, inflight};
  assign issue       = (state == READ) && (outstanding < 3'd2);
  assign bankWrap    = (row == lastCoord) && (col == lastCoord);
  assign lastIssue   = bankWrap && (pass == lastPass);

  // Sweep FSM; coordinates of an issued read ride one cycle behind it with the data.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state          <= WAIT;
      row            <= '0;
      col            <= '0;
      pass           <= 4'd0;
      gapCnt         <= 2'd0;
      o_AttnRam_Done <= 1'b0;
      inflight       <= 1'b0;
      rowQ           <= '0;
      colQ           <= '0;
      passQ          <= 4'd0;
      lastQ          <= 1'b0;
    end else begin
      o_AttnRam_Done <= 1'b0;
      inflight       <= issue;
      if (issue) begin
        rowQ  <= row;
        colQ  <= col;
        passQ <= pass;
        lastQ <= lastIssue;
      end
      case (state)
        WAIT: begin
          if (!i_AttnRAM_Empty) begin
            state <= READ;
            row   <= '0;
            col   <= '0;
            pass  <= 4'd0;
          end
        end
        READ: begin
          if (issue) begin
            if (lastIssue) begin
              state <= DRAIN;
            end else begin
              if (bankWrap) begin
                pass <= pass + 4'd1;
              end
`ifdef ATTN_RD_COLMAJOR_EN
              if (row == lastCoord) begin
                row <= '0;
                col <= col + 1'b1;
              end else begin
                row <= row + 1'b1;
              end
`else
              if (col == lastCoord) begin
                col <= '0;
                row <= row + 1'b1;
              end else begin
                col <= col + 1'b1;
              end
`endif
            end
          end
        end
        DRAIN: begin
          if (pop && m_last) begin
            state          <= REL;
            o_AttnRam_Done <= 1'b1;
          end
        end
        REL: begin
          state  <= GAP;
          gapCnt <= 2'(ATTN_GAP_CYCLES - 1);
        end
        GAP: begin
          if (gapCnt == 2'd0) begin
            state <= WAIT;
          end else begin
            gapCnt <= gapCnt - 2'd1;
          end
        end
        default: state <= WAIT;
      endcase
    end
  end

  attn_rd_skid #(
    .EW(EW)
  ) uSkid (
    .s_clk    (s_clk),
    .s_rst_n  (s_rst_n),
    .push     (inflight),
    .pushEntry({i_AttnRAM_data, rowQ, colQ, passQ, lastQ}),
    .pop      (pop),
    .headEntry(headEntry),
    .count    (skidCount)
  );

  assign {m_data, m_row, m_col, m_pass, m_last} = headEntry;

endmodule
